// File: rtl/ps2_pkg.sv
// Shared types and constants for the buffered PS/2 receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDps   = 2'd1,
        StCheck = 2'd2
    } state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Odd parity over data plus parity bit holds when the XOR of all nine bits is 1.
    function automatic logic odd_parity_ok(input logic [DATA_BITS:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             accept
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign do_pop = pop & ~empty;
    assign accept = push & (~full | do_pop);
    assign dout   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({accept, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: dout is gated while empty.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: clock glitch filter, frame FSM with watchdog,
// and a FWFT FIFO for received bytes.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2c,
    input  logic                 ps2d,
    input  logic                 rx_en,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow
);

    localparam int unsigned N_W  = $clog2(FRAME_BITS);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_W-1:0]  N_FIRST = N_W'(FRAME_BITS - 2);

    logic [FILTER_LEN-1:0] filter_q;
    logic                  fc_q, fc_d;
    logic                  fall_edge;

    state_e                state_q, state_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [FRAME_BITS-1:0] b_q, b_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic                  push;
    logic                  fifo_accept;

    always_comb begin
        fc_d = fc_q;
        if (&filter_q)      fc_d = 1'b1;
        else if (~|filter_q) fc_d = 1'b0;
    end

    assign fall_edge = fc_q & ~fc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_q <= '0;
            fc_q     <= 1'b0;
        end else begin
            filter_q <= {ps2c, filter_q[FILTER_LEN-1:1]};
            fc_q     <= fc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        b_d        = b_q;
        wd_d       = wd_q;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        overflow   = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall_edge && rx_en && (ps2d == START_BIT)) begin
                    b_d     = {ps2d, b_q[FRAME_BITS-1:1]};
                    n_d     = N_FIRST;
                    wd_d    = '0;
                    state_d = StDps;
                end
            end
            StDps: begin
                if (fall_edge) begin
                    b_d  = {ps2d, b_q[FRAME_BITS-1:1]};
                    wd_d = '0;
                    if (n_q == '0) state_d = StCheck;
                    else           n_d = n_q - N_W'(1);
                end else if (wd_q == WD_LAST) begin
                    frame_err = 1'b1;
                    b_d       = '0;
                    n_d       = '0;
                    wd_d      = '0;
                    state_d   = StIdle;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            StCheck: begin
                state_d = StIdle;
                // The start bit is guaranteed by the IDLE entry test; checked again defensively.
                if ((b_q[FRAME_BITS-1] != STOP_BIT) || (b_q[0] != START_BIT)) begin
                    frame_err = 1'b1;
                end else if (!odd_parity_ok(b_q[FRAME_BITS-2:1])) begin
                    parity_err = 1'b1;
                end else begin
                    push     = 1'b1;
                    overflow = ~fifo_accept;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
        end
    end

    ps2_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (b_q[DATA_BITS:1]),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .accept(fifo_accept)
    );

endmodule
